// File: rtl/uart_pkg.sv
`default_nettype none
// uart_pkg -- FSM state type and parameter defaults shared by the UART transmit arbiter.
// Revision: 1.0
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2
  } state_e;

  localparam int DATA_W_DEF      = 8;
  localparam int TIMEOUT_CYC_DEF = 32;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// rr_arbiter -- round-robin pick: first requester after last_grant, wrapping around.
// Revision: 1.0
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant_onehot,
  output logic [IDX_W-1:0]   grant_idx
);

  logic             found;
  logic [IDX_W-1:0] cand;

  // Offsets 1..NUM_REQ visit every index once, ending at last_grant itself.
  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    found        = 1'b0;
    cand         = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = IDX_W'((int'(last_grant) + off) % NUM_REQ);
      if (!found && req[cand]) begin
        found              = 1'b1;
        grant_onehot[cand] = 1'b1;
        grant_idx          = cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// uart_tx_arbiter -- round-robin arbiter feeding one UART transmitter, with done-edge watchdog.
// Revision: 1.0
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      tx_start,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_done,
  output logic [1:0]                grant_id,
  output logic                      busy,
  output logic                      timeout_err
);

  localparam int              WD_W     = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [WD_W-1:0] WD_MAX   = '1;
  localparam logic [1:0]      LAST_RST = 2'(NUM_REQ - 1);

  state_e             state_q, state_d;
  logic [1:0]         last_grant_q, last_grant_d;
  logic [1:0]         grant_id_q, grant_id_d;
  logic [DATA_W-1:0]  tx_data_q, tx_data_d;
  logic [WD_W-1:0]    wd_cnt_q, wd_cnt_d;
  logic               timeout_q, timeout_d;
  logic               done_hist_q;
  logic [NUM_REQ-1:0] grant_onehot;
  logic [1:0]         grant_idx;
  logic               done_rise;
  logic               accept;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (2)
  ) u_rr (
    .req          (req_valid),
    .last_grant   (last_grant_q),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx)
  );

  // A level still high from an earlier frame never completes a frame; only a fresh edge does.
  assign done_rise   = tx_done & ~done_hist_q;
  assign req_ready   = (state_q == IDLE) ? grant_onehot : '0;
  assign accept      = |(req_valid & req_ready);
  assign tx_start    = (state_q == START);
  assign busy        = (state_q != IDLE);
  assign tx_data     = tx_data_q;
  assign grant_id    = grant_id_q;
  assign timeout_err = timeout_q;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    tx_data_d    = tx_data_q;
    wd_cnt_d     = wd_cnt_q;
    timeout_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d      = START;
          tx_data_d    = req_data[int'(grant_idx)*DATA_W +: DATA_W];
          grant_id_d   = grant_idx;
          last_grant_d = grant_idx;
        end
      end
      START: begin
        state_d  = WAIT_DONE;
        wd_cnt_d = '0;
      end
      WAIT_DONE: begin
        // Completion wins over a coincident watchdog expiry.
        if (done_rise) begin
          state_d = IDLE;
        end else if (wd_cnt_q == WD_LAST) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else if (wd_cnt_q != WD_MAX) begin
          wd_cnt_d = wd_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= LAST_RST;
      grant_id_q   <= '0;
      tx_data_q    <= '0;
      wd_cnt_q     <= '0;
      timeout_q    <= 1'b0;
      done_hist_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      tx_data_q    <= tx_data_d;
      wd_cnt_q     <= wd_cnt_d;
      timeout_q    <= timeout_d;
      done_hist_q  <= tx_done;
    end
  end

endmodule
`default_nettype wire
